// File: rtl/mem_responder.sv
// Single-port word memory behind an OBI-style req/gnt/rvalid data port.
// One outstanding access; configurable grant wait and response latency.
module mem_responder #(
  parameter int ADDR_WIDTH  = 22,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int GNT_DELAY   = 0,
  parameter int RD_LATENCY  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic [1:0]            dbg_state_o
);

  // Handshake: the initiator holds req (with addr/we/be/wdata stable) until it
  // sees gnt high in the same cycle; the rising edge ending that cycle is the
  // access edge. Exactly one single-cycle rvalid follows each grant, in order.

  localparam int         IDX_W       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] GNT_DELAY_C = 4'(GNT_DELAY);
  localparam logic [3:0] RD_LAT_M1   = 4'(RD_LATENCY - 1);
  localparam bit         NO_DELAY    = (GNT_DELAY == 0);
  localparam bit         ONE_LAT     = (RD_LATENCY == 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              wait_cnt_q, wait_cnt_d;
  logic [3:0]              lat_cnt_q, lat_cnt_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0]   pend_q, pend_d;
  logic                    gnt_raw;
  logic                    gnt;
  logic [IDX_W-1:0]        word_idx;
  logic [DATA_WIDTH-1:0]   mem_rd;
  logic [DATA_WIDTH-1:0]   wr_word;
  logic [DATA_WIDTH-1:0]   resp_word;
  logic                    unused_addr;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH_WORDS];

  // Byte offset and bits above the depth are dropped, so addresses alias.
  assign word_idx    = data_addr_i[IDX_W+1:2];
  assign unused_addr = ^data_addr_i;
  assign mem_rd      = mem_q[word_idx];
  assign resp_word   = data_we_i ? '0 : mem_rd;

  always_comb begin
    wr_word = mem_rd;
    for (int b = 0; b < 4; b++) begin
      if (data_be_i[b]) begin
        wr_word[8*b +: 8] = data_wdata_i[8*b +: 8];
      end
    end
  end

  // Storage carries no reset so committed writes survive a reset pulse.
  always_ff @(posedge clk) begin
    if (gnt && data_we_i) begin
      mem_q[word_idx] <= wr_word;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    rdata_d    = rdata_q;
    pend_d     = pend_q;
    gnt_raw    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (data_req_i) begin
          if (NO_DELAY) begin
            gnt_raw = 1'b1;
          end else begin
            wait_cnt_d = GNT_DELAY_C;
            state_d    = STALL;
          end
        end
      end
      STALL: begin
        if (!data_req_i) begin
          wait_cnt_d = '0;
          state_d    = IDLE;
        end else if (wait_cnt_q <= 4'd1) begin
          // The IDLE load cycle already counts as one wait cycle.
          wait_cnt_d = '0;
          gnt_raw    = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      BUSY: begin
        if (lat_cnt_q <= 4'd1) begin
          lat_cnt_d = '0;
          rdata_d   = pend_q;
          state_d   = RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (data_req_i && NO_DELAY) begin
          gnt_raw = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    gnt = gnt_raw && reset;

    // A grant overrides whatever the state decided: the access edge is now.
    if (gnt) begin
      if (ONE_LAT) begin
        rdata_d = resp_word;
        state_d = RESP;
      end else begin
        pend_d    = resp_word;
        lat_cnt_d = RD_LAT_M1;
        state_d   = BUSY;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      lat_cnt_q  <= '0;
      rdata_q    <= '0;
      pend_q     <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      rdata_q    <= rdata_d;
      pend_q     <= pend_d;
    end
  end

  assign data_gnt_o    = gnt;
  assign data_rvalid_o = (state_q == RESP);
  assign data_rdata_o  = rdata_q;
  assign dbg_state_o   = state_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 22, byte-address width of data_addr_i.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data word width; only 32 is supported.
REQ-003 SHALL have parameter DEPTH_WORDS, default 1024, storage depth in 32-bit words; power of two.
REQ-004 SHALL have parameter GNT_DELAY, default 0, idle-request-to-grant wait cycles (0..15).
REQ-005 SHALL have parameter RD_LATENCY, default 1, grant-edge-to-rvalid cycles (1..15).
REQ-006 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port data_req_i, input, 1, request from the initiator.
REQ-009 SHALL have port data_addr_i, input, ADDR_WIDTH, byte address.
REQ-010 SHALL have port data_we_i, input, 1, 1=write, 0=read.
REQ-011 SHALL have port data_be_i, input, 4, byte enables for writes.
REQ-012 SHALL have port data_wdata_i, input, DATA_WIDTH, write data.
REQ-013 SHALL have port data_gnt_o, output, 1, request accepted this cycle.
REQ-014 SHALL have port data_rvalid_o, output, 1, response valid, one-cycle pulse.
REQ-015 SHALL have port data_rdata_o, output, DATA_WIDTH, read data, meaningful only with rvalid.

Function
REQ-016 SHALL implement FSM states IDLE, STALL, BUSY, RESP, with at most one outstanding request.
REQ-017 SHALL, in IDLE with req=1 and GNT_DELAY=0, assert data_gnt_o combinationally in the same cycle.
REQ-018 SHALL, in IDLE with req=1 and GNT_DELAY>0, load wait counter = GNT_DELAY, keep gnt=0, and go to STALL.
REQ-019 SHALL, in STALL, decrement the counter each cycle; when counter=0 and req=1, assert gnt combinationally.
REQ-020 SHALL, in STALL with req=0 (request withdrawn), return to IDLE without grant or response.
REQ-021 SHALL treat the grant cycle's rising edge as the access edge: capture we, addr, be, wdata; perform the write; sample read data.
REQ-022 SHALL, after the grant edge, go to RESP if RD_LATENCY=1, else to BUSY with latency counter = RD_LATENCY-1.
REQ-023 SHALL, in BUSY, decrement the latency counter and enter RESP when it reaches 0.
REQ-024 SHALL, in RESP, assert data_rvalid_o for exactly one cycle; total grant-edge-to-rvalid distance = RD_LATENCY cycles.
REQ-025 SHALL, in RESP with req=1 and GNT_DELAY=0, grant the next request in the same cycle (back-to-back); otherwise treat RESP as leaving to IDLE.
REQ-026 SHALL index storage by word = data_addr_i[log2(DEPTH_WORDS)+1:2]; ignore addr[1:0] and higher bits (address wraps modulo depth).
REQ-027 SHALL update only the bytes whose data_be_i bit is 1 on a write; be=0000 writes nothing but still produces rvalid.
REQ-028 SHALL return the stored word on a read response and 0 on a write response; data_rdata_o holds its value between responses.
REQ-029 SHALL guarantee exactly one rvalid per grant, in grant order; no rvalid without a prior grant.
REQ-030 SHALL never assert gnt in BUSY, or in RESP when GNT_DELAY>0.

Reset
REQ-031 SHALL, while reset=0, force state=IDLE, counters=0, data_gnt_o=0, data_rvalid_o=0, and data_rdata_o=0.
REQ-032 SHALL, on reset mid-transaction, abort with no rvalid; a write whose grant edge already occurred remains committed.
REQ-033 SHALL leave storage contents unaffected by reset.

Verification
REQ-034 SHALL cover defaults, write 0xFFFFFFFF to addr 0x80 with be=1111: gnt in the req cycle, rvalid 1 cycle later with rdata=0; a read of 0x80 then returns 0xFFFFFFFF.
REQ-035 SHALL cover a partial write of 0x12345678 to 0x84 with be=0101 over 0x00000000, then a read: rdata=0x00340078.
REQ-036 SHALL cover GNT_DELAY=3, RD_LATENCY=4 read: gnt in the 4th req cycle; rvalid exactly 4 cycles after the grant edge.
REQ-037 SHALL cover back-to-back reads of 0x80 and 0x84 with req held: the second gnt coincides with the first rvalid; responses arrive in order.
REQ-038 SHALL cover address wrap with DEPTH_WORDS=1024: a write at 0x1080 is read back at 0x0080.
REQ-039 SHALL cover reset pulled low in BUSY after a write grant: no rvalid; after reset release, a read returns the written data.
